// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths and types
// used by the round datapath blocks.
package aes_pkg;

  localparam int AES_BLOCK_W           = 128;
  localparam int AES128_NUM_ROUND_KEYS = 11;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

endpackage

// File: rtl/ark_pipe_stage.sv
// ark_pipe_stage: one valid/ready register slice
// carrying keyed data, round index and error flag.
module ark_pipe_stage
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_BLOCK_W,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [IDX_W-1:0]  i_round,
  input  logic              i_err,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_round,
  output logic              o_err
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_round;
  logic              r_err;
  logic              w_load;

  // Load when empty or when the current entry leaves this cycle.
  assign w_load = i_valid && (!r_valid || i_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_round <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load) begin
        r_data  <= i_data;
        r_round <= i_round;
        r_err   <= i_err;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_round = r_round;
  assign o_err   = r_err;

endmodule

// File: rtl/add_round_key_pipe.sv
// add_round_key_pipe: AddRoundKey with a round-key
// store and a PIPE-deep elastic valid/ready pipeline.
module add_round_key_pipe
  import aes_pkg::*;
#(
  parameter int DATA_W   = AES_BLOCK_W,
  parameter int NUM_KEYS = AES128_NUM_ROUND_KEYS,
  parameter int PIPE     = 2,
  localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_wr_clr,
  output logic              keys_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_round,
  input  logic              in_bypass,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_round,
  output logic              out_err,
  output logic              err_sticky
);

  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_KEYS - 1);
  localparam logic [IDX_W-1:0] LP_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   LP_NUM  = (IDX_W+1)'(NUM_KEYS);

  logic [DATA_W-1:0] r_store [NUM_KEYS];
  logic [IDX_W-1:0]  r_wr_ptr;
  logic              r_keys_ready;
  logic              r_err_sticky;

  logic [DATA_W-1:0] w_key;
  logic              w_err;

  logic [PIPE-1:0]   w_sv;
  logic [PIPE-1:0]   w_dn;
  logic [PIPE-1:0]   w_se;
  logic [DATA_W-1:0] w_sd [PIPE];
  logic [IDX_W-1:0]  w_sr [PIPE];

  // Clear wins over a same-cycle write; keys_ready survives wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_store[i] <= '0;
      end
      r_wr_ptr     <= '0;
      r_keys_ready <= 1'b0;
    end else if (key_wr_clr) begin
      r_wr_ptr     <= '0;
      r_keys_ready <= 1'b0;
    end else if (key_wr_en) begin
      r_store[r_wr_ptr] <= key_wr_data;
      if (r_wr_ptr == LP_LAST) begin
        r_wr_ptr     <= '0;
        r_keys_ready <= 1'b1;
      end else begin
        r_wr_ptr <= r_wr_ptr + LP_ONE;
      end
    end
  end

  always_comb begin
    w_key = '0;
    w_err = 1'b0;
    if (in_bypass) begin
      w_key = in_key;
    end else if (r_keys_ready && ({1'b0, in_round} < LP_NUM)) begin
      w_key = r_store[in_round];
    end else begin
      w_err = 1'b1;
    end
  end

  // Ready ripples from the output back, built from stage valids only.
  always_comb begin
    logic v_rdy;
    v_rdy = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      w_dn[k] = v_rdy;
      v_rdy   = !w_sv[k] || v_rdy;
    end
    in_ready = v_rdy;
  end

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    logic              w_iv;
    logic [DATA_W-1:0] w_id;
    logic [IDX_W-1:0]  w_ir;
    logic              w_ie;

    if (k == 0) begin : g_head
      assign w_iv = in_valid;
      assign w_id = in_data ^ w_key;
      assign w_ir = in_round;
      assign w_ie = w_err;
    end else begin : g_body
      assign w_iv = w_sv[k-1];
      assign w_id = w_sd[k-1];
      assign w_ir = w_sr[k-1];
      assign w_ie = w_se[k-1];
    end

    ark_pipe_stage #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_iv),
      .i_data  (w_id),
      .i_round (w_ir),
      .i_err   (w_ie),
      .i_ready (w_dn[k]),
      .o_valid (w_sv[k]),
      .o_data  (w_sd[k]),
      .o_round (w_sr[k]),
      .o_err   (w_se[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (w_sv[PIPE-1] && out_ready && w_se[PIPE-1]) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign keys_ready = r_keys_ready;
  assign err_sticky = r_err_sticky;
  assign out_valid  = w_sv[PIPE-1];
  assign out_data   = w_sd[PIPE-1];
  assign out_round  = w_sr[PIPE-1];
  assign out_err    = w_se[PIPE-1];

endmodule

// File: tb/tb_add_round_key_pipe.sv
// tb_add_round_key_pipe: directed vectors for the
// keyed pipeline, plus streaming runs at PIPE=1/2/4.
module tb_add_round_key_pipe;

  localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] NEWK = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [127:0] SK   = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk;
  logic         rst;
  logic         s_rst;
  logic         key_wr_en;
  logic [127:0] key_wr_data;
  logic         key_wr_clr;
  logic         keys_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_round;
  logic         in_bypass;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         out_err;
  logic         err_sticky;

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  add_round_key_pipe #(.PIPE(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .key_wr_en   (key_wr_en),
    .key_wr_data (key_wr_data),
    .key_wr_clr  (key_wr_clr),
    .keys_ready  (keys_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_round    (in_round),
    .in_bypass   (in_bypass),
    .in_key      (in_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_round   (out_round),
    .out_err     (out_err),
    .err_sticky  (err_sticky)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] kval(input int i);
    return K0 ^ {16{8'(i * 29)}};
  endfunction

  function automatic logic [127:0] sdat(input int i);
    return {16{8'(i * 37 + 5)}};
  endfunction

  task automatic wr_keys(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_wr_en   = 1'b1;
      key_wr_data = kval(first + i);
    end
    @(negedge clk);
    key_wr_en = 1'b0;
    #1;
  endtask

  // One transaction; checks 2-cycle latency and the delivered payload.
  task automatic xfer(input string tag, input logic [127:0] d,
                      input logic [3:0] rnd, input logic byp,
                      input logic [127:0] k, input logic wr,
                      input logic [127:0] wd, input logic [127:0] exp_d,
                      input logic exp_e);
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = d;
    in_round    = rnd;
    in_bypass   = byp;
    in_key      = k;
    key_wr_en   = wr;
    key_wr_data = wd;
    #1;
    chk({tag, ".rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    key_wr_en = 1'b0;
    #1;
    chk({tag, ".v1"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, ".v2"}, out_valid, 1);
    chk({tag, ".data"}, out_data, exp_d);
    chk({tag, ".rnd"}, out_round, rnd);
    chk({tag, ".err"}, out_err, exp_e);
  endtask

  initial begin
    s_rst = 1'b1;
    #12;
    s_rst = 1'b0;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_s
    localparam int P = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    logic         s_in_valid;
    logic         s_in_ready;
    logic [127:0] s_in_data;
    logic [3:0]   s_in_round;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [127:0] s_out_data;
    logic [3:0]   s_out_round;
    logic         s_out_err;
    logic         s_keys_ready;
    logic         s_err_sticky;
    logic         done;

    add_round_key_pipe #(.PIPE(P)) u_s (
      .clk         (clk),
      .rst         (s_rst),
      .key_wr_en   (1'b0),
      .key_wr_data ('0),
      .key_wr_clr  (1'b0),
      .keys_ready  (s_keys_ready),
      .in_valid    (s_in_valid),
      .in_ready    (s_in_ready),
      .in_data     (s_in_data),
      .in_round    (s_in_round),
      .in_bypass   (1'b1),
      .in_key      (SK),
      .out_valid   (s_out_valid),
      .out_ready   (s_out_ready),
      .out_data    (s_out_data),
      .out_round   (s_out_round),
      .out_err     (s_out_err),
      .err_sticky  (s_err_sticky)
    );

    initial begin
      int sent;
      int got;
      int occ;
      int cyc;
      logic ordy;
      done        = 1'b0;
      s_in_valid  = 1'b0;
      s_in_data   = '0;
      s_in_round  = '0;
      s_out_ready = 1'b0;
      sent = 0;
      got  = 0;
      occ  = 0;
      cyc  = 0;
      repeat (3) @(negedge clk);
      while (got < 8 && cyc < 200) begin
        @(negedge clk);
        ordy        = (cyc % 2) == 0;
        s_out_ready = ordy;
        s_in_valid  = sent < 8;
        s_in_data   = sdat(sent);
        s_in_round  = 4'(sent);
        #1;
        chk($sformatf("s%0d.rdy", P), s_in_ready,
            !(occ == P && !ordy));
        if (s_out_valid) begin
          chk($sformatf("s%0d.data", P), s_out_data, sdat(got) ^ SK);
          chk($sformatf("s%0d.rnd", P), s_out_round, 4'(got));
          chk($sformatf("s%0d.err", P), s_out_err, 0);
          if (ordy) begin
            got++;
            occ--;
          end
        end
        if (s_in_valid && s_in_ready) begin
          sent++;
          occ++;
        end
        cyc++;
      end
      s_in_valid = 1'b0;
      chk($sformatf("s%0d.count", P), got, 8);
      chk($sformatf("s%0d.sticky", P), s_err_sticky, 0);
      chk($sformatf("s%0d.kr", P), s_keys_ready, 0);
      done = 1'b1;
    end
  end

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst         = 1'b1;
    key_wr_en   = 1'b0;
    key_wr_data = '0;
    key_wr_clr  = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_round    = '0;
    in_bypass   = 1'b0;
    in_key      = '0;
    out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst.rdy", in_ready, 1);
    chk("rst.ov", out_valid, 0);
    chk("rst.od", out_data, 0);
    chk("rst.kr", keys_ready, 0);
    chk("rst.sticky", err_sticky, 0);

    xfer("byp", PT, 4'd0, 1'b1, K0, 1'b0, '0, CT, 1'b0);

    wr_keys(0, 10);
    chk("load10.kr", keys_ready, 0);
    wr_keys(10, 1);
    chk("load11.kr", keys_ready, 1);
    xfer("r0", PT, 4'd0, 1'b0, '0, 1'b0, '0, CT, 1'b0);
    xfer("r5", PT2, 4'd5, 1'b0, '0, 1'b0, '0, PT2 ^ kval(5), 1'b0);
    xfer("r10", PT2, 4'd10, 1'b0, '0, 1'b0, '0, PT2 ^ kval(10), 1'b0);
    chk("pre.sticky", err_sticky, 0);

    xfer("r11", PT, 4'd11, 1'b0, '0, 1'b0, '0, PT, 1'b1);
    @(negedge clk);
    #1;
    chk("r11.sticky", err_sticky, 1);

    @(negedge clk);
    key_wr_clr  = 1'b1;
    key_wr_en   = 1'b1;
    key_wr_data = '1;
    @(negedge clk);
    key_wr_clr = 1'b0;
    key_wr_en  = 1'b0;
    #1;
    chk("clr.kr", keys_ready, 0);
    xfer("clr", PT, 4'd0, 1'b0, '0, 1'b0, '0, PT, 1'b1);
    wr_keys(0, 10);
    chk("reld10.kr", keys_ready, 0);
    wr_keys(10, 1);
    chk("reld11.kr", keys_ready, 1);
    xfer("reld", PT, 4'd0, 1'b0, '0, 1'b0, '0, CT, 1'b0);

    wr_keys(0, 3);
    xfer("wr3", PT, 4'd3, 1'b0, '0, 1'b1, NEWK, PT ^ kval(3), 1'b0);
    xfer("new3", PT, 4'd3, 1'b0, '0, 1'b0, '0, PT ^ NEWK, 1'b0);
    chk("keep.sticky", err_sticky, 1);

    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = PT;
    in_round  = 4'd1;
    in_bypass = 1'b1;
    in_key    = K0;
    @(negedge clk);
    in_data  = PT2;
    in_round = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("fly.ov", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.ov", out_valid, 0);
    chk("arst.od", out_data, 0);
    chk("arst.sticky", err_sticky, 0);
    chk("arst.kr", keys_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stale%0d", i), out_valid, 0);
    end
    xfer("post", PT, 4'd0, 1'b1, K0, 1'b0, '0, CT, 1'b0);

    for (int c = 0; c < 500; c++) begin
      if (g_s[0].done && g_s[1].done && g_s[2].done) break;
      @(negedge clk);
    end
    chk("stream.done", {g_s[0].done, g_s[1].done, g_s[2].done}, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
